// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: shares the data-memory port between the cpu and the DMA
// engine through a BR/BG handshake, routes the owner's address/data/strobes
// to memory, counts DMA block writes per grant and pulses done on release.
// Optional build macro DMA_WATCHDOG_EN adds a grant watchdog that forces a
// release after TIMEOUT_CYCLES grant cycles and raises a sticky timeout flag.
//
// Handshake: the DMA raises br and holds it for as long as it wants the bus.
// bg is registered and goes high the cycle after br is sampled with
// cpu_mem_busy low; the DMA owns the bus exactly while bg is high. Dropping
// br ends the grant; bg falls on the next edge and done pulses for one cycle
// while the bus is already back with the cpu.
module dma_bus_arbiter #(
   parameter int WORD_SIZE      = 16,
   parameter int BLOCK_SIZE     = 64,
   parameter int CNT_W          = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_d_readM,
   input  logic                  cpu_d_writeM,
   input  logic [WORD_SIZE-1:0]  cpu_d_address,
   input  logic [BLOCK_SIZE-1:0] cpu_d_wdata,
   output logic [BLOCK_SIZE-1:0] cpu_d_rdata,
   input  logic                  cpu_mem_busy,
   output logic                  cpu_stall,
   input  logic                  br,
   output logic                  bg,
   input  logic                  dma_write,
   input  logic [WORD_SIZE-1:0]  dma_addr,
   input  logic [BLOCK_SIZE-1:0] dma_data,
   output logic                  mem_readM,
   output logic                  mem_writeM,
   output logic [WORD_SIZE-1:0]  mem_address,
   output logic [BLOCK_SIZE-1:0] mem_wdata,
   input  logic [BLOCK_SIZE-1:0] mem_rdata,
   output logic [CNT_W-1:0]      xfer_blocks,
   output logic                  done,
   output logic                  timeout,
   output logic [1:0]            dbg_state_o
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WAIT_CPU = 2'd1;
   localparam logic [1:0] S_GRANT    = 2'd2;
   localparam logic [1:0] S_RELEASE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             bg_q;
   logic             dma_write_q;
   logic [CNT_W-1:0] xfer_q, xfer_d;
   logic             force_rel;   // watchdog forces GRANT -> RELEASE
   logic             br_ok;       // br as seen by IDLE/WAIT_CPU
   logic             grant_entry;

`ifdef DMA_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_q, wd_d;
   logic            hold_q, hold_d;     // br must be seen low after a forced release
   logic            timeout_q, timeout_d;

   // Watchdog: count grant cycles, force release on the last allowed one.
   always_comb begin
      force_rel = (state_q == S_GRANT) && br && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      br_ok     = br && !hold_q;
      wd_d      = wd_q;
      if (grant_entry)
         wd_d = '0;
      else if (state_q == S_GRANT)
         wd_d = wd_q + 1'b1;
      hold_d    = hold_q;
      if (force_rel)
         hold_d = 1'b1;
      else if (!br)
         hold_d = 1'b0;
      timeout_d = timeout_q | force_rel;
   end

   // Watchdog registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_q      <= '0;
         hold_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign force_rel = 1'b0;
   assign br_ok     = br;
   assign timeout   = 1'b0;
`endif

   // Next-state logic for bus ownership.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (br_ok) state_d = cpu_mem_busy ? S_WAIT_CPU : S_GRANT;
         S_WAIT_CPU: if (!br_ok) state_d = S_IDLE;
                     else if (!cpu_mem_busy) state_d = S_GRANT;
         S_GRANT:    if (!br || force_rel) state_d = S_RELEASE;
         S_RELEASE:  state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   assign grant_entry = (state_d == S_GRANT) && (state_q != S_GRANT);

   // Block counter: cleared on grant entry, counts rising edges of dma_write while granted.
   always_comb begin
      xfer_d = xfer_q;
      if (grant_entry)
         xfer_d = '0;
      else if ((state_q == S_GRANT) && dma_write && !dma_write_q && (xfer_q != '1))
         xfer_d = xfer_q + 1'b1;
   end

   // State, grant, write-edge and counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         bg_q        <= 1'b0;
         dma_write_q <= 1'b0;
         xfer_q      <= '0;
      end else begin
         state_q     <= state_d;
         bg_q        <= (state_d == S_GRANT);
         dma_write_q <= dma_write;
         xfer_q      <= xfer_d;
      end
   end

   // Memory port mux, driven from registered ownership so RELEASE already routes the cpu.
   always_comb begin
      if (state_q == S_GRANT) begin
         mem_readM   = 1'b0;
         mem_writeM  = dma_write;
         mem_address = dma_addr;
         mem_wdata   = dma_data;
      end else begin
         mem_readM   = cpu_d_readM;
         mem_writeM  = cpu_d_writeM;
         mem_address = cpu_d_address;
         mem_wdata   = cpu_d_wdata;
      end
   end

   assign cpu_d_rdata = mem_rdata;
   assign cpu_stall   = (state_q == S_GRANT) && (cpu_d_readM || cpu_d_writeM);
   assign bg          = bg_q;
   assign done        = (state_q == S_RELEASE);
   assign xfer_blocks = xfer_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a cycle-level ownership model of the arbiter.
module tb_dma_bus_arbiter;

   localparam int WS   = 16;
   localparam int BS   = 64;
   localparam int CW   = 3;
   localparam int TMO  = 8;
   localparam int CMAX = (1 << CW) - 1;
`ifdef DMA_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          cpu_d_readM, cpu_d_writeM;
   logic [WS-1:0] cpu_d_address;
   logic [BS-1:0] cpu_d_wdata, cpu_d_rdata;
   logic          cpu_mem_busy, cpu_stall;
   logic          br, bg;
   logic          dma_write;
   logic [WS-1:0] dma_addr;
   logic [BS-1:0] dma_data;
   logic          mem_readM, mem_writeM;
   logic [WS-1:0] mem_address;
   logic [BS-1:0] mem_wdata, mem_rdata;
   logic [CW-1:0] xfer_blocks;
   logic          done, timeout;
   logic [1:0]    dbg_state;

   dma_bus_arbiter #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_d_readM(cpu_d_readM), .cpu_d_writeM(cpu_d_writeM),
      .cpu_d_address(cpu_d_address), .cpu_d_wdata(cpu_d_wdata),
      .cpu_d_rdata(cpu_d_rdata), .cpu_mem_busy(cpu_mem_busy), .cpu_stall(cpu_stall),
      .br(br), .bg(bg), .dma_write(dma_write), .dma_addr(dma_addr), .dma_data(dma_data),
      .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .xfer_blocks(xfer_blocks),
      .done(done), .timeout(timeout), .dbg_state_o(dbg_state)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   bit m_owns;      // DMA holds the bus
   bit m_rel;       // one-cycle handback in progress
   int m_cnt;       // blocks written this grant
   bit m_prev_wr;   // dma_write seen at previous edge
   bit m_timeout;
   bit m_block;     // waiting for br to drop after a forced release
   int m_gcyc;      // grant cycles elapsed

   task automatic model_step();
      bit prev;
      bit forced;
      forced = 1'b0;
      if (!reset_n) begin
         m_owns = 0; m_rel = 0; m_cnt = 0; m_prev_wr = 0;
         m_timeout = 0; m_block = 0; m_gcyc = 0;
      end else begin
         prev      = m_prev_wr;
         m_prev_wr = dma_write;
         if (m_owns) begin
            if (dma_write && !prev && m_cnt < CMAX) m_cnt++;
            m_gcyc++;
            if (!br) begin
               m_owns = 0; m_rel = 1;
            end else if (WD_ON && m_gcyc == TMO) begin
               m_owns = 0; m_rel = 1; m_timeout = 1; m_block = 1; forced = 1'b1;
            end
         end else if (m_rel) begin
            m_rel = 0;
         end else if (br && !m_block && !cpu_mem_busy) begin
            m_owns = 1; m_cnt = 0; m_gcyc = 0;
         end
         if (!forced && !br) m_block = 0;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("bg",        64'(bg),          64'(m_owns));
      check("done",      64'(done),        64'(m_rel));
      check("xfer",      64'(xfer_blocks), 64'(m_cnt));
      check("timeout",   64'(timeout),     64'(m_timeout));
      check("stall",     64'(cpu_stall),   64'(m_owns && (cpu_d_readM || cpu_d_writeM)));
      check("mem_read",  64'(mem_readM),   m_owns ? 64'd0 : 64'(cpu_d_readM));
      check("mem_write", 64'(mem_writeM),  m_owns ? 64'(dma_write) : 64'(cpu_d_writeM));
      check("mem_addr",  64'(mem_address), m_owns ? 64'(dma_addr) : 64'(cpu_d_address));
      check("mem_wdata", mem_wdata,        m_owns ? dma_data : cpu_d_wdata);
      check("rdata",     cpu_d_rdata,      mem_rdata);
   endtask

   // ---------------- driver ----------------
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic dma_pulse(input logic [WS-1:0] a);
      dma_addr = a; dma_data = {$urandom, $urandom}; dma_write = 1'b1;
      cycle();
      dma_write = 1'b0;
      cycle();
   endtask

   initial begin
      reset_n = 1'b0; cpu_d_readM = 0; cpu_d_writeM = 0; cpu_d_address = 16'h1234;
      cpu_d_wdata = 64'hC0C0_C0C0_1111_2222; cpu_mem_busy = 0; br = 0; dma_write = 0;
      dma_addr = 16'h0; dma_data = 64'h0; mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      #2;
      cycle();
      cycle();
      check("rst_bg", 64'(bg), 64'd0);
      check("rst_xfer", 64'(xfer_blocks), 64'd0);
      check("rst_addr", 64'(mem_address), 64'h1234);
      reset_n = 1'b1;
      cycle();

      // 1: grant one cycle after br with busy low
      br = 1'b1; dma_addr = 16'h01F4;
      cycle();
      check("t1_bg", 64'(bg), 64'd1);
      check("t1_addr", 64'(mem_address), 64'h01F4);
      check("t1_stall", 64'(cpu_stall), 64'd0);

      // 3: three block writes then release
      dma_pulse(16'h01F4);
      dma_pulse(16'h01F8);
      dma_pulse(16'h01FC);
      br = 1'b0;
      cycle();
      check("t3_done", 64'(done), 64'd1);
      check("t3_bg", 64'(bg), 64'd0);
      check("t3_xfer", 64'(xfer_blocks), 64'd3);
      cycle();
      check("t3_done_low", 64'(done), 64'd0);
      check("t3_xfer_hold", 64'(xfer_blocks), 64'd3);

      // 2: busy holds the grant off
      br = 1'b1; cpu_mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t2_bg_wait", 64'(bg), 64'd0);
      end
      cpu_mem_busy = 1'b0;
      cycle();
      check("t2_bg", 64'(bg), 64'd1);
      check("t2_xfer_clr", 64'(xfer_blocks), 64'd0);

      // 4: cpu read during grant stalls, then reaches memory after release
      cpu_d_readM = 1'b1; cpu_d_address = 16'h0050;
      #1;
      check("t4_stall", 64'(cpu_stall), 64'd1);
      check("t4_rd", 64'(mem_readM), 64'd0);
      br = 1'b0;
      cycle();
      check("t4_addr", 64'(mem_address), 64'h0050);
      check("t4_rd_rel", 64'(mem_readM), 64'd1);
      cpu_d_readM = 1'b0;
      cycle();

      // 5: reset in the middle of a grant
      br = 1'b1;
      cycle();
      dma_pulse(16'h0200);
      dma_pulse(16'h0204);
      check("t5_xfer2", 64'(xfer_blocks), 64'd2);
      reset_n = 1'b0; cpu_d_address = 16'h0ABC;
      cycle();
      check("t5_bg", 64'(bg), 64'd0);
      check("t5_xfer", 64'(xfer_blocks), 64'd0);
      check("t5_addr", 64'(mem_address), 64'h0ABC);
      reset_n = 1'b1; br = 1'b0;
      cycle();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 7) == 0) br = ~br;
         cpu_mem_busy  = ($urandom_range(0, 2) == 0);
         dma_write     = $urandom_range(0, 1);
         dma_addr      = WS'($urandom);
         dma_data      = {$urandom, $urandom};
         cpu_d_readM   = $urandom_range(0, 1);
         cpu_d_writeM  = $urandom_range(0, 1);
         cpu_d_address = WS'($urandom);
         cpu_d_wdata   = {$urandom, $urandom};
         mem_rdata     = {$urandom, $urandom};
         reset_n       = ($urandom_range(0, 99) != 0);
         cycle();
      end
      reset_n = 1'b1; dma_write = 1'b0; cpu_mem_busy = 1'b0; br = 1'b0;
      cycle();
      cycle();

`ifdef DMA_WATCHDOG_EN
      // 6: watchdog forces a release and blocks regrant until br drops
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1; br = 1'b1;
      for (int i = 0; i < TMO; i++) begin
         cycle();
         check("t6_bg_held", 64'(bg), 64'd1);
      end
      cycle();
      check("t6_bg_forced", 64'(bg), 64'd0);
      check("t6_timeout", 64'(timeout), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t6_no_regrant", 64'(bg), 64'd0);
      end
      br = 1'b0;
      cycle();
      br = 1'b1;
      cycle();
      check("t6_regrant", 64'(bg), 64'd1);
      check("t6_sticky", 64'(timeout), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
